// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// supported range of the parallel word width.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;

endpackage

// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle of the bit serializer.
// master = word producer / serial consumer, slave = the serializer itself.
interface bit_serializer_if
    import ser_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              shift_en;
    logic              dout;
    logic              dout_valid;
    logic              busy;

    modport master (
        output in_data, in_valid, shift_en,
        input  in_ready, dout, dout_valid, busy
    );

    modport slave (
        input  in_data, in_valid, shift_en,
        output in_ready, dout, dout_valid, busy
    );
endinterface

// File: rtl/ser_bit_counter.sv
// Down-counter tracking how many data bits are still to be presented after
// the one currently on dout. o_tc flags that the current bit is the last one.
module ser_bit_counter
    import ser_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_count;

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tc = (r_count == '0);
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input and a shift_en bit tick.
// The first bit leaves one cycle after acceptance; a new word can be taken on
// the cycle the last bit advances, giving a gapless stream.
// Optional feature: define SER_PARITY_EN to append an even-parity bit per word.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    bit_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_width_check
        $error("bit_serializer: DATA_W out of supported range");
    end

    ser_state_t        r_state;
    logic [DATA_W-1:0] r_sreg;
    logic              r_dout;
    logic              r_dout_valid;
    logic              r_busy;
`ifdef SER_PARITY_EN
    logic              r_parity;
`endif

    logic              w_ready;
    logic              w_accept;
    logic              w_tc;
    logic              w_dec;
    logic              w_first_bit;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_load_shift;
    logic [DATA_W-1:0] w_sreg_shift;

    // The shift register holds the bits not yet presented, next one at the exit end.
    assign w_first_bit  = MSB_FIRST ? bus.in_data[DATA_W-1] : bus.in_data[0];
    assign w_next_bit   = MSB_FIRST ? r_sreg[DATA_W-1] : r_sreg[0];
    assign w_load_shift = MSB_FIRST ? (bus.in_data << 1) : (bus.in_data >> 1);
    assign w_sreg_shift = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);

    // Ready when idle, or when the final bit of the word advances this cycle.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:   w_ready = 1'b1;
`ifdef SER_PARITY_EN
                SHIFT:  w_ready = 1'b0;
                PARITY: w_ready = bus.shift_en;
`else
                SHIFT:  w_ready = bus.shift_en && w_tc;
`endif
                default: w_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = bus.in_valid && w_ready;
    assign w_dec    = (r_state == SHIFT) && bus.shift_en && !w_tc;

    ser_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (CNT_W'(DATA_W - 1)),
        .i_dec      (w_dec),
        .o_tc       (w_tc)
    );

    // FSM and serial datapath; every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sreg       <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state      <= SHIFT;
            r_sreg       <= w_load_shift;
            r_dout       <= w_first_bit;
            r_dout_valid <= 1'b1;
            r_busy       <= 1'b1;
`ifdef SER_PARITY_EN
            r_parity     <= ^bus.in_data;
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    if (bus.shift_en) begin
                        if (!w_tc) begin
                            r_sreg <= w_sreg_shift;
                            r_dout <= w_next_bit;
                        end else begin
`ifdef SER_PARITY_EN
                            r_state      <= PARITY;
                            r_dout       <= r_parity;
                            r_dout_valid <= 1'b1;
`else
                            r_state      <= IDLE;
                            r_dout       <= 1'b0;
                            r_dout_valid <= 1'b0;
                            r_busy       <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    if (bus.shift_en) begin
                        r_state      <= IDLE;
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state      <= IDLE;
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance driven with
// identical stimulus, compared each cycle against a word/bit-index model,
// plus directed scenarios with fixed expected sequences.
// Honours SER_PARITY_EN when defined for the build.
`timescale 1ns/1ps
module tb_bit_serializer;
    localparam int DW = 8;
`ifdef SER_PARITY_EN
    localparam int NBITS = DW + 1;
`else
    localparam int NBITS = DW;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serializer_if #(.DATA_W(DW)) if_m ();
    bit_serializer_if #(.DATA_W(DW)) if_l ();

    bit_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    bit_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_l)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: per instance, whether a word is on the line, the word,
    // and the index of the bit currently shown (DW = parity slot).
    bit              m_act  [2];
    logic [DW-1:0]   m_word [2];
    int              m_idx  [2];
    logic            o_rdy  [2];

    function automatic logic model_bit(input logic [DW-1:0] w, input int idx, input bit msb);
        if (idx >= DW) return ^w;
        return msb ? w[DW-1-idx] : w[idx];
    endfunction

    // One clock: drive inputs, check in_ready, clock, check registered outputs.
    task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d, input bit s);
        bit   exp_rdy [2];
        logic got_rdy [2];
        logic got_do  [2];
        logic got_dv  [2];
        logic got_bz  [2];
        logic exp_do;
        rst = r;
        if_m.in_valid = v; if_l.in_valid = v;
        if_m.in_data  = d; if_l.in_data  = d;
        if_m.shift_en = s; if_l.shift_en = s;
        #1;
        got_rdy[0] = if_m.in_ready;
        got_rdy[1] = if_l.in_ready;
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = !r && (!m_act[k] || (s && (m_idx[k] == NBITS - 1)));
            checks++;
            if (got_rdy[k] !== exp_rdy[k]) begin
                errors++;
                $display("FAIL in_ready[%0d] cycle %0d: got %b expected %b", k, cyc, got_rdy[k], exp_rdy[k]);
            end
            o_rdy[k] = got_rdy[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_act[k] = 1'b0;
            end else if (v && exp_rdy[k]) begin
                m_act[k]  = 1'b1;
                m_word[k] = d;
                m_idx[k]  = 0;
            end else if (m_act[k] && s) begin
                if (m_idx[k] == NBITS - 1) m_act[k] = 1'b0;
                else m_idx[k] = m_idx[k] + 1;
            end
        end
        @(negedge clk);
        cyc++;
        got_do[0] = if_m.dout; got_dv[0] = if_m.dout_valid; got_bz[0] = if_m.busy;
        got_do[1] = if_l.dout; got_dv[1] = if_l.dout_valid; got_bz[1] = if_l.busy;
        for (int k = 0; k < 2; k++) begin
            exp_do = m_act[k] ? model_bit(m_word[k], m_idx[k], (k == 0)) : 1'b0;
            checks++;
            if (got_do[k] !== exp_do) begin
                errors++;
                $display("FAIL dout[%0d] cycle %0d: got %b expected %b", k, cyc, got_do[k], exp_do);
            end
            checks++;
            if (got_dv[k] !== m_act[k]) begin
                errors++;
                $display("FAIL dout_valid[%0d] cycle %0d: got %b expected %b", k, cyc, got_dv[k], m_act[k]);
            end
            checks++;
            if (got_bz[k] !== m_act[k]) begin
                errors++;
                $display("FAIL busy[%0d] cycle %0d: got %b expected %b", k, cyc, got_bz[k], m_act[k]);
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 8'hA5, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({if_m.dout, if_m.dout_valid, if_m.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000", {if_m.dout, if_m.dout_valid, if_m.busy});
        end
        checks++;
        if (o_rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b expected 0", o_rdy[0]);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (o_rdy[0] !== 1'b1 || o_rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b%b expected 11", o_rdy[0], o_rdy[1]);
        end
    endtask

    // 8'hB0 MSB-first: 1,0,1,1,0,0,0,0 (then parity 1 when enabled), then idle.
    task automatic test_msb_first();
        logic [7:0] pat = 8'b1011_0000;
        logic exp_do;
        cycle(1'b0, 1'b1, 8'hB0, 1'b1);
        for (int i = 1; i <= NBITS + 1; i++) begin
            exp_do = (i <= 8) ? pat[8-i] : ((i == 9 && NBITS == 9) ? 1'b1 : 1'b0);
            checks++;
            if (if_m.dout !== exp_do || if_m.dout_valid !== (i <= NBITS)) begin
                errors++;
                $display("FAIL msb_seq cycle %0d: got dout=%b vld=%b expected dout=%b vld=%b",
                         i, if_m.dout, if_m.dout_valid, exp_do, (i <= NBITS));
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (o_rdy[0] !== (i >= NBITS)) begin
                errors++;
                $display("FAIL msb_ready cycle %0d: got %b expected %b", i, o_rdy[0], (i >= NBITS));
            end
        end
    endtask

    // 8'h0D LSB-first: 1,0,1,1,0,0,0,0 (parity of 0D is 1).
    task automatic test_lsb_first();
        logic [7:0] pat = 8'b1011_0000;
        logic exp_do;
        cycle(1'b0, 1'b1, 8'h0D, 1'b1);
        for (int i = 1; i <= NBITS + 1; i++) begin
            exp_do = (i <= 8) ? pat[8-i] : ((i == 9 && NBITS == 9) ? 1'b1 : 1'b0);
            checks++;
            if (if_l.dout !== exp_do || if_l.dout_valid !== (i <= NBITS)) begin
                errors++;
                $display("FAIL lsb_seq cycle %0d: got dout=%b vld=%b expected dout=%b vld=%b",
                         i, if_l.dout, if_l.dout_valid, exp_do, (i <= NBITS));
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    // 8'hB0 then 8'hFF held valid: ready pulses at 0 and NBITS, gapless output.
    task automatic test_back_to_back();
        int  dv_cnt = 0;
        bit  exp_r;
        for (int c = 0; c <= 2 * NBITS + 1; c++) begin
            cycle(1'b0, (c <= NBITS), (c == 0) ? 8'hB0 : 8'hFF, 1'b1);
            exp_r = (c == 0) || (c == NBITS) || (c >= 2 * NBITS);
            checks++;
            if (o_rdy[0] !== exp_r) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d: got %b expected %b", c, o_rdy[0], exp_r);
            end
            if (if_m.dout_valid === 1'b1) dv_cnt++;
        end
        checks++;
        if (dv_cnt != 2 * NBITS) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d expected %0d", dv_cnt, 2 * NBITS);
        end
    endtask

    // shift_en every third cycle: first bit lasts 1 cycle, the rest 3 each.
    task automatic test_slow_shift();
        int dv_cnt = 0;
        cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        if (if_m.dout_valid === 1'b1) dv_cnt++;
        for (int c = 1; c <= 3 * NBITS + 3; c++) begin
            cycle(1'b0, 1'b0, 8'h00, (c % 3 == 1));
            if (if_m.dout_valid === 1'b1) dv_cnt++;
        end
        checks++;
        if (dv_cnt != 1 + 3 * (NBITS - 1)) begin
            errors++;
            $display("FAIL slow_word_cycles: got %0d expected %0d", dv_cnt, 1 + 3 * (NBITS - 1));
        end
    endtask

    // Reset raised at cycle 4 of 8'hB0 (held two cycles): word aborted.
    task automatic test_reset_mid();
        for (int c = 0; c <= 9; c++) begin
            cycle((c == 4) || (c == 5), (c == 0), 8'hB0, 1'b1);
            if (c >= 4) begin
                checks++;
                if (if_m.dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_valid cycle %0d: got %b expected 0", c + 1, if_m.dout_valid);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (o_rdy[0] !== (c == 6)) begin
                    errors++;
                    $display("FAIL abort_ready cycle %0d: got %b expected %b", c, o_rdy[0], (c == 6));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
                  8'($urandom), ($urandom_range(0, 99) < 55));
        end
        for (int c = 0; c < 3 * NBITS; c++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        if_m.in_valid = 1'b0; if_l.in_valid = 1'b0;
        if_m.in_data  = '0;   if_l.in_data  = '0;
        if_m.shift_en = 1'b0; if_l.shift_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_act[k]  = 1'b0;
            m_word[k] = '0;
            m_idx[k]  = 0;
            o_rdy[k]  = 1'b0;
        end
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_slow_shift();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: parallel word width, 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit DATA_W-1 shifted first, 0 = bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port in_data, input, DATA_W bits: parallel word to serialize.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 The block SHALL have port shift_en, input, 1 bit: bit-rate tick; the serial stream advances only when high.
REQ-009 The block SHALL have port dout, output, 1 bit: serial bit, feeding the downstream sequence detector's din.
REQ-010 The block SHALL have port dout_valid, output, 1 bit: dout carries a live bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT and PARITY (PARITY present only per REQ-024).
REQ-013 The block SHALL accept a word on a cycle where in_valid and in_ready are both high; a word is never dropped or duplicated.
REQ-014 in_ready SHALL be high in IDLE, and in SHIFT when shift_en is high and the final data bit is presented with no parity stage following; otherwise low.
REQ-015 On acceptance, the word SHALL be loaded into a DATA_W shift register, the bit counter set to DATA_W-1, and the FSM moved to SHIFT.
REQ-016 dout and dout_valid SHALL be registered; the first bit SHALL appear the cycle after acceptance (latency 1), regardless of shift_en.
REQ-017 In SHIFT with shift_en high, the next bit SHALL be presented per MSB_FIRST and the counter decremented; with shift_en low, dout, dout_valid and the counter SHALL hold.
REQ-018 When the counter is 0 and shift_en is high, the FSM SHALL go to PARITY if enabled, else to SHIFT with a new word if accepted that cycle (gapless back-to-back), else to IDLE.
REQ-019 In IDLE, dout SHALL be 0 and dout_valid SHALL be 0.
REQ-020 in_valid is ignored while in_ready is low; in_data need only be stable on the acceptance cycle.

Reset
REQ-021 When rst is high, the FSM SHALL go to IDLE, the shift register and counter SHALL clear, and dout, dout_valid and busy SHALL be 0 on the next edge.
REQ-022 Reset asserted mid-word SHALL abort the word with no further bits emitted; rst has priority over in_valid and shift_en.
REQ-023 in_ready SHALL be low while rst is high and high on the first cycle after rst deasserts.

Configuration
REQ-024 Macro SER_PARITY_EN SHALL control parity: when defined, after the last data bit one PARITY state emits the even-parity bit (XOR of the word) with dout_valid high, advanced by shift_en; in_ready follows REQ-014 with the parity bit treated as the final bit; when undefined, the PARITY state and its logic SHALL be absent.

Structure
REQ-025 Package ser_pkg SHALL hold the state enumeration typedef (IDLE, SHIFT, PARITY) and the DATA_W range limits.
REQ-026 The bit counter with load, decrement and terminal-count output SHALL be sub-module ser_bit_counter; the FSM and datapath live in bit_serializer.

Verification
REQ-027 With MSB_FIRST=1, shift_en=1 and 8'hB0 accepted at cycle 0, dout SHALL be 1,0,1,1,0,0,0,0 on cycles 1-8 with dout_valid high, then 0 on cycle 9.
REQ-028 With 8'hB0 then 8'hFF held valid, dout_valid SHALL be high on 16 consecutive cycles and in_ready SHALL pulse on cycles 0 and 8.
REQ-029 With MSB_FIRST=0 and 8'h0D, dout SHALL be 1,0,1,1,0,0,0,0.
REQ-030 With shift_en=1 every third cycle, each bit SHALL be held 3 cycles and the full word SHALL take 22 cycles after acceptance.
REQ-031 With rst pulsed at cycle 4 of 8'hB0, dout_valid SHALL be 0 from cycle 5 and in_ready SHALL be 1 from cycle 6.
REQ-032 With SER_PARITY_EN defined and 8'hB0 sent, cycle 9 SHALL carry parity bit 1 with dout_valid high, and in_ready SHALL be high on cycle 9, not cycle 8.
